// File: rtl/cache_ctrl_wb_if.sv
// cache_ctrl_wb_if
// Bundles the CPU request/response signals, the tag-array status bits and
// the cache/memory control strobes of the cache controller.
//   Strobe, DRW      CPU request and its type (1 = write)
//   M, V, D          tag match, valid and dirty bits of the indexed line
//   DReady           request complete (one cycle per request)
//   W, SetDirty      cache array write enable and dirty value written
//   WSel, RSel       cache write-data source / CPU read-data source
//   MStrobe, MRW     memory request and direction (1 = write)
//   MAddrSel         memory address select (1 = victim address)
//   Busy             controller is not idle
// Modports: slave = controller side, master = requester/array side.
//
// Handshake: the requester raises Strobe (with DRW) while Busy is low and
// must drop it and keep it low until DReady has been seen; the controller
// samples Strobe/DRW only while idle and pulses DReady for exactly one
// cycle per accepted request. There is no queuing.
interface cache_ctrl_wb_if;
    logic Strobe;
    logic DRW;
    logic M;
    logic V;
    logic D;
    logic DReady;
    logic W;
    logic SetDirty;
    logic MStrobe;
    logic MRW;
    logic MAddrSel;
    logic RSel;
    logic WSel;
    logic Busy;

    modport slave (
        input  Strobe, DRW, M, V, D,
        output DReady, W, SetDirty, MStrobe, MRW, MAddrSel, RSel, WSel, Busy
    );

    modport master (
        output Strobe, DRW, M, V, D,
        input  DReady, W, SetDirty, MStrobe, MRW, MAddrSel, RSel, WSel, Busy
    );
endinterface

// File: rtl/cache_ctrl_wb.sv
// cache_ctrl_wb
// Controller FSM for a direct-mapped cache with a selectable write policy:
// WRITE_BACK=1 gives write-back + write-allocate with dirty-victim eviction,
// WRITE_BACK=0 gives write-through + no-allocate. Memory accesses last
// WAIT_CYCLES cycles, timed by an internal down-counter.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   bus        cache_ctrl_wb_if.slave (CPU, tag status, cache/memory controls)
//   state_dbg  current FSM state encoding, for observation only
module cache_ctrl_wb #(
    parameter int WAIT_CYCLES = 4,
    parameter int CTR_W       = 8,
    parameter int WRITE_BACK  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_ctrl_wb_if.slave       bus,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_EVICT  = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_REFILL = 3'd4;
    localparam logic [2:0] S_MERGE  = 3'd5;
    localparam logic [2:0] S_WT_MEM = 3'd6;

    localparam bit              WB       = (WRITE_BACK != 0);
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(WAIT_CYCLES - 1);
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic             op;
    logic [CTR_W-1:0] ctr;
    logic             ctr_load;
    logic             ctr_zero;
    logic             hit;

    assign hit       = bus.M & bus.V;
    assign ctr_zero  = (ctr == '0);
    assign state_dbg = state;

    // Next state, counter reload and all outputs. Outputs depend only on
    // the state, except in LOOKUP where the tag status bits steer them.
    always_comb begin
        next_state   = state;
        ctr_load     = 1'b0;
        bus.DReady   = 1'b0;
        bus.W        = 1'b0;
        bus.SetDirty = 1'b0;
        bus.MStrobe  = 1'b0;
        bus.MRW      = 1'b0;
        bus.MAddrSel = 1'b0;
        bus.RSel     = 1'b0;
        bus.WSel     = 1'b0;
        bus.Busy     = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.Strobe) next_state = S_LOOKUP;
            end

            S_LOOKUP: begin
                bus.Busy = 1'b1;
                if (hit && !op) begin
                    bus.DReady = 1'b1;
                    next_state = S_IDLE;
                end else if (hit && op && WB) begin
                    bus.W        = 1'b1;
                    bus.SetDirty = 1'b1;
                    bus.DReady   = 1'b1;
                    next_state   = S_IDLE;
                end else if (op && !WB) begin
                    // Write-through: update the line only if present, the
                    // memory write happens either way.
                    bus.W      = hit;
                    next_state = S_WT_MEM;
                    ctr_load   = 1'b1;
                end else if (WB && bus.V && bus.D) begin
                    next_state = S_EVICT;
                    ctr_load   = 1'b1;
                end else begin
                    next_state = S_FILL;
                    ctr_load   = 1'b1;
                end
            end

            S_EVICT: begin
                bus.Busy     = 1'b1;
                bus.MStrobe  = 1'b1;
                bus.MRW      = 1'b1;
                bus.MAddrSel = 1'b1;
                if (ctr_zero) begin
                    next_state = S_FILL;
                    ctr_load   = 1'b1;
                end
            end

            S_FILL: begin
                bus.Busy    = 1'b1;
                bus.MStrobe = 1'b1;
                if (ctr_zero) next_state = S_REFILL;
            end

            S_REFILL: begin
                bus.Busy = 1'b1;
                bus.W    = 1'b1;
                bus.WSel = 1'b1;
                if (!op) begin
                    // Read data is forwarded from memory in the same cycle
                    // the line is written.
                    bus.DReady = 1'b1;
                    bus.RSel   = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    next_state = S_MERGE;
                end
            end

            S_MERGE: begin
                bus.Busy     = 1'b1;
                bus.W        = 1'b1;
                bus.SetDirty = 1'b1;
                bus.DReady   = 1'b1;
                next_state   = S_IDLE;
            end

            S_WT_MEM: begin
                bus.Busy    = 1'b1;
                bus.MStrobe = 1'b1;
                bus.MRW     = 1'b1;
                if (ctr_zero) begin
                    bus.DReady = 1'b1;
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op    <= 1'b0;
            ctr   <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && bus.Strobe) op <= bus.DRW;
            // Loading WAIT_CYCLES-1 and exiting on zero makes each memory
            // state last exactly WAIT_CYCLES cycles; a load of 0 never
            // decrements, so WAIT_CYCLES=1 cannot underflow.
            if (ctr_load) begin
                ctr <= CTR_LOAD;
            end else if ((state == S_EVICT || state == S_FILL || state == S_WT_MEM)
                         && !ctr_zero) begin
                ctr <= ctr - CTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Testbench for cache_ctrl_wb. Three instances cover write-back with a
// 4-cycle memory, write-through with a 4-cycle memory, and write-back with a
// 1-cycle memory. Per-cycle vectors hold the inputs driven in a cycle and the
// outputs expected in that same cycle; row k of a sequence is cycle k-1 of
// the request (row 0 raises Strobe, row 1 is LOOKUP).
module tb_cache_ctrl_wb;

    // Output vector bit positions.
    localparam logic [8:0] O_DR  = 9'h100;
    localparam logic [8:0] O_W   = 9'h080;
    localparam logic [8:0] O_SD  = 9'h040;
    localparam logic [8:0] O_MS  = 9'h020;
    localparam logic [8:0] O_MRW = 9'h010;
    localparam logic [8:0] O_MAS = 9'h008;
    localparam logic [8:0] O_RS  = 9'h004;
    localparam logic [8:0] O_WS  = 9'h002;
    localparam logic [8:0] O_BZ  = 9'h001;

    // Input vector bit positions {Strobe, DRW, M, V, D}.
    localparam logic [4:0] I_S = 5'b10000;
    localparam logic [4:0] I_W = 5'b01000;
    localparam logic [4:0] I_M = 5'b00100;
    localparam logic [4:0] I_V = 5'b00010;
    localparam logic [4:0] I_D = 5'b00001;

    localparam logic [8:0] EVICT_O  = O_MS | O_MRW | O_MAS | O_BZ;
    localparam logic [8:0] FILL_O   = O_MS | O_BZ;
    localparam logic [8:0] WT_O     = O_MS | O_MRW | O_BZ;
    localparam logic [8:0] RD_REF_O = O_W | O_WS | O_DR | O_RS | O_BZ;
    localparam logic [8:0] WR_REF_O = O_W | O_WS | O_BZ;
    localparam logic [8:0] MERGE_O  = O_W | O_SD | O_DR | O_BZ;

    typedef struct {
        int         sel;
        logic [4:0] in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic reset;
    logic [4:0] in_wb4, in_wt4, in_wb1;
    logic [8:0] out_wb4, out_wt4, out_wb1;
    logic [2:0] st_wb4, st_wt4, st_wb1;

    int n_tests;
    int n_fail;
    vec_t vecs[$];

    cache_ctrl_wb_if if_wb4 ();
    cache_ctrl_wb_if if_wt4 ();
    cache_ctrl_wb_if if_wb1 ();

    cache_ctrl_wb #(.WAIT_CYCLES(4), .CTR_W(8), .WRITE_BACK(1)) dut_wb4 (
        .clk(clk), .reset(reset), .bus(if_wb4.slave), .state_dbg(st_wb4));
    cache_ctrl_wb #(.WAIT_CYCLES(4), .CTR_W(8), .WRITE_BACK(0)) dut_wt4 (
        .clk(clk), .reset(reset), .bus(if_wt4.slave), .state_dbg(st_wt4));
    cache_ctrl_wb #(.WAIT_CYCLES(1), .CTR_W(8), .WRITE_BACK(1)) dut_wb1 (
        .clk(clk), .reset(reset), .bus(if_wb1.slave), .state_dbg(st_wb1));

    assign {if_wb4.Strobe, if_wb4.DRW, if_wb4.M, if_wb4.V, if_wb4.D} = in_wb4;
    assign {if_wt4.Strobe, if_wt4.DRW, if_wt4.M, if_wt4.V, if_wt4.D} = in_wt4;
    assign {if_wb1.Strobe, if_wb1.DRW, if_wb1.M, if_wb1.V, if_wb1.D} = in_wb1;

    assign out_wb4 = {if_wb4.DReady, if_wb4.W, if_wb4.SetDirty, if_wb4.MStrobe, if_wb4.MRW,
                      if_wb4.MAddrSel, if_wb4.RSel, if_wb4.WSel, if_wb4.Busy};
    assign out_wt4 = {if_wt4.DReady, if_wt4.W, if_wt4.SetDirty, if_wt4.MStrobe, if_wt4.MRW,
                      if_wt4.MAddrSel, if_wt4.RSel, if_wt4.WSel, if_wt4.Busy};
    assign out_wb1 = {if_wb1.DReady, if_wb1.W, if_wb1.SetDirty, if_wb1.MStrobe, if_wb1.MRW,
                      if_wb1.MAddrSel, if_wb1.RSel, if_wb1.WSel, if_wb1.Busy};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [8:0] get_out(int sel);
        case (sel)
            0:       return out_wb4;
            1:       return out_wt4;
            default: return out_wb1;
        endcase
    endfunction

    function automatic void add(int sel, logic [4:0] in, logic [8:0] exp, string name);
        vec_t v;
        v.sel  = sel;
        v.in   = in;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic drive(int sel, logic [4:0] v);
        in_wb4 = (sel == 0) ? v : 5'b0;
        in_wt4 = (sel == 1) ? v : 5'b0;
        in_wb1 = (sel == 2) ? v : 5'b0;
    endtask

    task automatic check(string name, logic [8:0] got, logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- stimulus / scoreboard ----------------
    initial begin
        int cyc;
        int got_cyc;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        drive(0, 5'b0);

        // Vector table.
        // WB, read hit.
        add(0, I_S, '0, "wb_rd_hit_c0");
        add(0, I_M | I_V, O_DR | O_BZ, "wb_rd_hit_c1");
        add(0, '0, '0, "wb_rd_hit_idle");
        // WB, write hit: written dirty, done in LOOKUP.
        add(0, I_S | I_W, '0, "wb_wr_hit_c0");
        add(0, I_M | I_V, O_W | O_SD | O_DR | O_BZ, "wb_wr_hit_c1");
        add(0, '0, '0, "wb_wr_hit_idle");
        // WB, read miss with dirty victim: EVICT 2-5, FILL 6-9, REFILL 10.
        add(0, I_S, '0, "wb_rd_dmiss_c0");
        add(0, I_V | I_D, O_BZ, "wb_rd_dmiss_lookup");
        for (int i = 0; i < 4; i++) add(0, I_M | I_V, EVICT_O, "wb_rd_dmiss_evict");
        for (int i = 0; i < 4; i++) add(0, I_S, FILL_O, "wb_rd_dmiss_fill");
        add(0, '0, RD_REF_O, "wb_rd_dmiss_refill");
        add(0, '0, '0, "wb_rd_dmiss_idle");
        // WB, write miss, clean (V=0 with D=1 is still clean): FILL 2-5, REFILL 6, MERGE 7.
        add(0, I_S | I_W, '0, "wb_wr_cmiss_c0");
        add(0, I_M | I_D, O_BZ, "wb_wr_cmiss_lookup");
        for (int i = 0; i < 4; i++) add(0, '0, FILL_O, "wb_wr_cmiss_fill");
        add(0, '0, WR_REF_O, "wb_wr_cmiss_refill");
        add(0, '0, MERGE_O, "wb_wr_cmiss_merge");
        add(0, '0, '0, "wb_wr_cmiss_idle");
        // WT, write hit: line updated clean, memory write 2-5, DReady in 5.
        add(1, I_S | I_W, '0, "wt_wr_hit_c0");
        add(1, I_M | I_V | I_D, O_W | O_BZ, "wt_wr_hit_lookup");
        for (int i = 0; i < 3; i++) add(1, '0, WT_O, "wt_wr_hit_mem");
        add(1, '0, WT_O | O_DR, "wt_wr_hit_done");
        add(1, '0, '0, "wt_wr_hit_idle");
        // WT, write miss: no cache write at all.
        add(1, I_S | I_W, '0, "wt_wr_miss_c0");
        add(1, I_V | I_D, O_BZ, "wt_wr_miss_lookup");
        for (int i = 0; i < 3; i++) add(1, I_M | I_V, WT_O, "wt_wr_miss_mem");
        add(1, '0, WT_O | O_DR, "wt_wr_miss_done");
        add(1, '0, '0, "wt_wr_miss_idle");
        // WT, read miss on a dirty line: never evicts.
        add(1, I_S, '0, "wt_rd_miss_c0");
        add(1, I_V | I_D, O_BZ, "wt_rd_miss_lookup");
        for (int i = 0; i < 4; i++) add(1, '0, FILL_O, "wt_rd_miss_fill");
        add(1, '0, RD_REF_O, "wt_rd_miss_refill");
        add(1, '0, '0, "wt_rd_miss_idle");
        // WAIT_CYCLES=1, clean read miss: FILL in 2, DReady in 3.
        add(2, I_S, '0, "w1_rd_miss_c0");
        add(2, '0, O_BZ, "w1_rd_miss_lookup");
        add(2, '0, FILL_O, "w1_rd_miss_fill");
        add(2, '0, RD_REF_O, "w1_rd_miss_refill");
        add(2, '0, '0, "w1_rd_miss_idle");
        // WAIT_CYCLES=1, back-to-back read hits: DReady in 1 and 3.
        add(2, I_S, '0, "w1_b2b_c0");
        add(2, I_M | I_V, O_DR | O_BZ, "w1_b2b_c1");
        add(2, I_S, '0, "w1_b2b_c2");
        add(2, I_M | I_V, O_DR | O_BZ, "w1_b2b_c3");
        add(2, '0, '0, "w1_b2b_idle");
        // WAIT_CYCLES=1, dirty write miss: EVICT 2, FILL 3, REFILL 4, MERGE 5.
        add(2, I_S | I_W, '0, "w1_wr_dmiss_c0");
        add(2, I_V | I_D, O_BZ, "w1_wr_dmiss_lookup");
        add(2, '0, EVICT_O, "w1_wr_dmiss_evict");
        add(2, '0, FILL_O, "w1_wr_dmiss_fill");
        add(2, '0, WR_REF_O, "w1_wr_dmiss_refill");
        add(2, '0, MERGE_O, "w1_wr_dmiss_merge");
        add(2, '0, '0, "w1_wr_dmiss_idle");

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_wb4", out_wb4, '0);
        check("reset_out_wt4", out_wt4, '0);
        check("reset_out_wb1", out_wb1, '0);
        check("reset_state", {6'b0, st_wb4}, 9'd0);
        @(negedge clk);
        reset = 1'b1;

        // Apply vector table, one row per cycle.
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].sel, vecs[i].in);
            @(negedge clk);
            check(vecs[i].name, get_out(vecs[i].sel), vecs[i].exp);
        end

        // Reset mid-FILL: outputs drop immediately, then a hit still completes in cycle 1.
        @(posedge clk); #1 drive(0, I_S);
        @(posedge clk); #1 drive(0, '0);
        @(posedge clk); #1 drive(0, '0);
        @(negedge clk);
        check("rst_pre_fill", out_wb4, FILL_O);
        #2 reset = 1'b0;
        #1;
        check("rst_async_out", out_wb4, '0);
        check("rst_async_state", {6'b0, st_wb4}, 9'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, I_S);
        @(posedge clk); #1 drive(0, I_M | I_V);
        @(negedge clk);
        check("rst_then_hit_c1", out_wb4, O_DR | O_BZ);
        @(posedge clk); #1 drive(0, '0);
        @(negedge clk);
        check("rst_then_hit_idle", out_wb4, '0);

        // Latency of a dirty write miss with tag status held constant
        // (status ignored outside LOOKUP): DReady expected in cycle 2*4+3.
        @(posedge clk); #1 drive(0, I_S | I_W | I_V | I_D);
        @(posedge clk); #1 drive(0, I_V | I_D);
        cyc     = 1;
        got_cyc = -1;
        while (cyc <= 40) begin
            @(negedge clk);
            if (if_wb4.DReady) begin
                got_cyc = cyc;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        check("wb_wr_dmiss_latency", 9'(got_cyc), 9'd11);
        @(posedge clk);
        @(negedge clk);
        check("wb_wr_dmiss_one_pulse", {8'b0, if_wb4.DReady}, 9'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
